// File: rtl/ac_pkg.sv
// Shared constants for the AC controller and room plant: widths, mode encoding, thresholds.
// Pure declarations; no timing or flow control involved.
package ac_pkg;

    localparam int TEMP_W = 5;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_COOL = 2'b01,
        MODE_HEAT = 2'b10
    } mode_t;

    localparam logic [TEMP_W-1:0] TEMP_MAX = 5'd31;
    localparam logic [TEMP_W-1:0] TEMP_MIN = 5'd0;

    // Controller thresholds: heat below LOW, cool above HIGH, settle at TARGET.
    localparam logic [TEMP_W-1:0] TEMP_LOW    = 5'd18;
    localparam logic [TEMP_W-1:0] TEMP_TARGET = 5'd20;
    localparam logic [TEMP_W-1:0] TEMP_HIGH   = 5'd22;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Both commands asserted together is illegal and falls back to idle.
    function automatic mode_t decode_mode(input logic heating, input logic cooling);
        mode_t m;
        m = MODE_IDLE;
        if (heating && !cooling) m = MODE_HEAT;
        else if (cooling && !heating) m = MODE_COOL;
        return m;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running step counter: tick is high while count equals the runtime terminal value.
// Wraps to zero after the terminal count or on clear; no backpressure.
module step_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] terminal,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    assign tick = (count == terminal);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/room_thermal_model.sv
// Room plant: temperature ramps while heating/cooling and drifts to ambient when idle.
// Outputs are registered, one edge after the commands are sampled; no backpressure.
module room_thermal_model
    import ac_pkg::*;
#(
    parameter int                STEP_CYCLES  = 4,
    parameter int                DRIFT_CYCLES = 8,
    parameter logic [TEMP_W-1:0] INIT_TEMP    = 5'd20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              heating,
    input  logic              cooling,
    input  logic [TEMP_W-1:0] ambient,
    output logic [TEMP_W-1:0] temperature,
    output logic              fault
);

    localparam int CNT_W = $clog2(max_int(STEP_CYCLES, DRIFT_CYCLES));
    localparam logic [CNT_W-1:0] STEP_TERM  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIFT_TERM = CNT_W'(DRIFT_CYCLES - 1);

    mode_t             mode;
    mode_t             mode_nxt;
    logic              mode_change;
    logic [CNT_W-1:0]  terminal;
    logic              tick;
    logic              update;
    logic [TEMP_W-1:0] temp_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode <= MODE_IDLE;
        end else begin
            mode <= mode_nxt;
        end
    end

    // Idle with and without the fault flag decode to the same mode, so the
    // timer keeps running across that transition.
    always_comb begin
        mode_nxt    = decode_mode(heating, cooling);
        mode_change = (mode_nxt != mode);
        terminal    = (mode == MODE_IDLE) ? DRIFT_TERM : STEP_TERM;
    end

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (mode_change),
        .terminal (terminal),
        .tick     (tick)
    );

    assign update = tick && !mode_change;

    always_comb begin
        temp_nxt = temperature;
        if (update) begin
            unique case (mode)
                MODE_HEAT: begin
                    if (temperature != TEMP_MAX) temp_nxt = temperature + 1'b1;
                end
                MODE_COOL: begin
                    if (temperature != TEMP_MIN) temp_nxt = temperature - 1'b1;
                end
                default: begin
                    if (ambient > temperature)      temp_nxt = temperature + 1'b1;
                    else if (ambient < temperature) temp_nxt = temperature - 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            temperature <= INIT_TEMP;
            fault       <= 1'b0;
        end else begin
            temperature <= temp_nxt;
            fault       <= heating && cooling;
        end
    end

endmodule

// File: tb/tb_room_thermal_model.sv
// Bench for room_thermal_model: fixed vector table, ramp/drift sequences and random
// commands checked every cycle against a run-length based reference model.
module tb_room_thermal_model;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       heating = 1'b0;
    logic       cooling = 1'b0;
    logic [4:0] ambient = 5'd20;
    logic [4:0] temperature;
    logic       fault;

    int total = 0;
    int bad   = 0;

    // Reference state: command class (0 idle, 1 cool, 2 heat), how many edges
    // it has been sampled in a row, the temperature and the fault flag.
    int m_cmd   = 0;
    int m_run   = 1;
    int m_temp  = 20;
    int m_fault = 0;

    always #5 clk = ~clk;

    room_thermal_model #(
        .STEP_CYCLES  (4),
        .DRIFT_CYCLES (8),
        .INIT_TEMP    (5'd20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .heating     (heating),
        .cooling     (cooling),
        .ambient     (ambient),
        .temperature (temperature),
        .fault       (fault)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A new command is held for one edge with no update; after that the
    // temperature moves whenever (run-1) is a whole multiple of the period.
    task automatic model_edge(input logic r, input logic h, input logic c, input int amb);
        int cmd;
        int period;
        if (!r) begin
            m_temp = 20; m_fault = 0; m_cmd = 0; m_run = 1;
        end else begin
            m_fault = (h && c) ? 1 : 0;
            cmd = (h && !c) ? 2 : ((c && !h) ? 1 : 0);
            if (cmd != m_cmd) begin
                m_cmd = cmd;
                m_run = 1;
            end else begin
                m_run++;
                period = (m_cmd == 0) ? 8 : 4;
                if ((m_run - 1) % period == 0) begin
                    if (m_cmd == 2)           m_temp = (m_temp < 31) ? m_temp + 1 : 31;
                    else if (m_cmd == 1)      m_temp = (m_temp > 0) ? m_temp - 1 : 0;
                    else if (amb > m_temp)    m_temp = m_temp + 1;
                    else if (amb < m_temp)    m_temp = m_temp - 1;
                end
            end
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
    task automatic step(input logic r, input logic h, input logic c, input logic [4:0] amb);
        rst_n = r; heating = h; cooling = c; ambient = amb;
        @(posedge clk);
        model_edge(r, h, c, int'(amb));
        @(negedge clk);
        check("model_temp", int'(temperature), m_temp);
        check("model_fault", int'(fault), m_fault);
    endtask

    typedef struct {
        logic       r;
        logic       h;
        logic       c;
        logic [4:0] amb;
        logic [4:0] et;
        logic       ef;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // Reset with both commands high, first heat ramp, one-cycle glitch, fault burst.
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 5'd20, 5'd20, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'd20, 5'd20, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 5'd20, 5'd20, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd20, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd20, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd20, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd20, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd21, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'd20, 5'd21, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd21, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd21, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd21, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd21, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 5'd20, 5'd22, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 5'd20, 5'd22, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 5'd20, 5'd22, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 5'd20, 5'd22, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 5'd20, 5'd22, 1'b0};

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].r, vecs[i].h, vecs[i].c, vecs[i].amb);
            check($sformatf("vec%0d_temp", i), int'(temperature), int'(vecs[i].et));
            check($sformatf("vec%0d_fault", i), int'(fault), int'(vecs[i].ef));
        end

        // Heat ramp to saturation and hold.
        step(1'b0, 1'b0, 1'b0, 5'd20);
        step(1'b0, 1'b0, 1'b0, 5'd20);
        for (int e = 1; e <= 65; e++) begin
            step(1'b1, 1'b1, 1'b0, 5'd20);
            if (e == 5)  check("heat_e5", int'(temperature), 21);
            if (e == 9)  check("heat_e9", int'(temperature), 22);
            if (e == 44) check("heat_e44", int'(temperature), 30);
            if (e == 45) check("heat_e45", int'(temperature), 31);
            if (e == 65) check("heat_hold", int'(temperature), 31);
        end

        // Cool ramp to zero, then drift up to ambient 3.
        step(1'b0, 1'b0, 1'b0, 5'd20);
        for (int e = 1; e <= 85; e++) begin
            step(1'b1, 1'b0, 1'b1, 5'd3);
            if (e == 5)  check("cool_e5", int'(temperature), 19);
            if (e == 80) check("cool_e80", int'(temperature), 1);
            if (e == 81) check("cool_e81", int'(temperature), 0);
            if (e == 85) check("cool_hold", int'(temperature), 0);
        end
        for (int e = 1; e <= 40; e++) begin
            step(1'b1, 1'b0, 1'b0, 5'd3);
            if (e == 8)  check("drift_up_e8", int'(temperature), 0);
            if (e == 9)  check("drift_up_e9", int'(temperature), 1);
            if (e == 18) check("drift_up_e18", int'(temperature), 2);
            if (e == 27) check("drift_up_e27", int'(temperature), 3);
            if (e == 40) check("drift_up_hold", int'(temperature), 3);
        end

        // Idle drift down to 15; one cooling edge first so idle begins with a mode change.
        step(1'b0, 1'b0, 1'b0, 5'd15);
        step(1'b1, 1'b0, 1'b1, 5'd15);
        for (int e = 1; e <= 50; e++) begin
            step(1'b1, 1'b0, 1'b0, 5'd15);
            if (e == 8)  check("drift_dn_e8", int'(temperature), 20);
            if (e == 9)  check("drift_dn_e9", int'(temperature), 19);
            if (e == 17) check("drift_dn_e17", int'(temperature), 18);
            if (e == 41) check("drift_dn_e41", int'(temperature), 15);
            if (e == 50) check("drift_dn_hold", int'(temperature), 15);
        end

        // Random command bursts, ambient changes and occasional reset.
        begin
            logic       h;
            logic       c;
            logic       r;
            logic [4:0] amb;
            int         hold;
            amb = 5'd10;
            for (int n = 0; n < 400; n++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: begin h = 1'b1; c = 1'b0; end
                    3, 4, 5: begin h = 1'b0; c = 1'b1; end
                    6:       begin h = 1'b1; c = 1'b1; end
                    default: begin h = 1'b0; c = 1'b0; end
                endcase
                if ($urandom_range(0, 3) == 0) amb = 5'($urandom_range(0, 31));
                r = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
                for (int k = 0; k < hold; k++) step(r, h, c, amb);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
